multisim_pull_buffer: RTL
=========================

MULTISIM_PULL_BUFFER -- requirements
Module: multisim_pull_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of one data word (matches the upstream pull server word).
REQ-002 SHALL have parameter DEPTH, default 4, number of buffered words; power of two, >= 2.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have in_vld  input  1  upstream word valid (driven by pull server data_vld).
REQ-006 SHALL have in_rdy  output  1  buffer can accept a word (drives pull server data_rdy).
REQ-007 SHALL have in_data  input  DATA_WIDTH  upstream word.
REQ-008 SHALL have out_vld  output  1  buffered word available to consumer.
REQ-009 SHALL have out_rdy  input  1  consumer accepts word.
REQ-010 SHALL have out_data  output  DATA_WIDTH  oldest buffered word.
REQ-011 SHALL have level  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-012 SHALL have starve_cnt  output  32  count of cycles with out_rdy=1 and out_vld=0.

Function
REQ-013 SHALL perform a push on a cycle with in_vld && in_rdy and a pop on a cycle with out_vld && out_rdy.
REQ-014 SHALL drive in_rdy = (level < DEPTH), from registered state only; no combinational path from out_rdy to in_rdy.
REQ-015 SHALL drive out_vld = (level != 0) and out_data = storage[rd_ptr], both from registered state only; no combinational path from in_* to out_*.
REQ-016 SHALL have latency of exactly 1 cycle: a word pushed into an empty buffer at edge N is presented with out_vld=1 after edge N; no bypass path.
REQ-017 SHALL deliver words in strict push order, with no loss or duplication.
REQ-018 SHALL update level per cycle: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-019 SHALL accept simultaneous push and pop when 0 < level < DEPTH; level unchanged, both pointers advance.
REQ-020 SHALL not push when full (in_rdy=0); in_data ignored even if in_vld=1; a pop when full frees one slot and raises in_rdy on the next cycle.
REQ-021 SHALL not pop when empty; out_rdy ignored and out_data don't-care.
REQ-022 SHALL keep wr_ptr and rd_ptr as $clog2(DEPTH)-bit counters wrapping DEPTH-1 -> 0 with no gap.
REQ-023 SHALL hold out_data stable while out_vld=1 and out_rdy=0.
REQ-024 SHALL tolerate in_vld deasserting without a push (upstream DPI delay gaps) with no state change.

Reset
REQ-025 SHALL, while rst_n=0, force level=0, wr_ptr=0, rd_ptr=0, out_vld=0, in_rdy=1 (after reset release), starve_cnt=0; storage contents not reset.
REQ-026 SHALL flush any buffered words on reset asserted mid-operation; no buffered word is delivered after rst_n rises.
REQ-027 SHALL drive in_rdy=0 while rst_n=0 so no push is accepted during reset.

Configuration
REQ-028 SHALL use macro MULTISIM_PULL_BUFFER_STATS_EN to control starvation statistics.
REQ-029 SHALL, with the macro defined, increment starve_cnt on every cycle with out_rdy=1 && out_vld=0, saturating at 32'hFFFF_FFFF.
REQ-030 SHALL, without the macro, tie starve_cnt to 0 and synthesize no counter logic; port list unchanged.

Verification
REQ-031 SHALL cover single word: reset, push 64'hDEAD_BEEF with out_rdy=1 -> out_vld=1 one cycle later with out_data=64'hDEAD_BEEF, level 1 -> 0 after the pop.
REQ-032 SHALL cover fill to full: DEPTH=4, out_rdy=0, push 1,2,3,4 -> level=4, in_rdy=0; in_vld=1 with 5 -> ignored; then drain -> 1,2,3,4 in order.
REQ-033 SHALL cover streaming: level=2, in_vld=out_rdy=1 for 10 cycles -> level stays 2, 10 words out in order across pointer wrap.
REQ-034 SHALL cover reset mid-operation: level=3, pull rst_n low 1 cycle -> level=0, out_vld=0; next push appears with no stale words.
REQ-035 SHALL cover starvation (macro defined): empty, out_rdy=1 for 7 cycles -> starve_cnt=7; macro undefined -> starve_cnt=0.
REQ-036 SHALL cover backpressure hold: out_vld=1, out_rdy=0 for 5 cycles with pushes -> out_data unchanged and level rises to DEPTH and holds there.

Source files
------------

// File: rtl/multisim_pull_buffer.sv
// multisim_pull_buffer: DEPTH-entry registered FIFO between the pull server and its consumer.
// Define MULTISIM_PULL_BUFFER_STATS_EN to build the starve_cnt statistics counter.
module multisim_pull_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [31:0]                  starve_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_level == FULL_LEVEL);
    assign w_empty  = (r_level == '0);

    // Ready is gated by rst_n so nothing can be accepted while reset is held.
    assign in_rdy   = rst_n & ~w_full;
    assign out_vld  = ~w_empty;
    assign out_data = r_mem[r_rd_ptr];
    assign level    = r_level;

    assign w_push   = in_vld & in_rdy;
    assign w_pop    = out_vld & out_rdy;

    // Storage is deliberately not reset; level and pointers alone decide validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef MULTISIM_PULL_BUFFER_STATS_EN
    logic [31:0] r_starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (out_rdy && w_empty && (r_starve_cnt != 32'hFFFF_FFFF)) begin
            r_starve_cnt <= r_starve_cnt + 32'd1;
        end
    end

    assign starve_cnt = r_starve_cnt;
`else
    assign starve_cnt = '0;
`endif

endmodule
